pe_array_ctrl: RTL
==================

// Module: pe_array_ctrl
// PURPOSE
//  Initiator side of the PE start/done/Ack handshake. Runs one background-removal job over NUM_PE
//  parallel pe instances: sum phase, average of per-PE sums into expected RGB, bg-removal phase.
//  Sits between the host/job interface and the PE array. Drives Start_Sum, Start_BgRemoval, Ack
//  and the broadcast parameters; consumes the PE done flags (Qsd, Qbgd) and sum buses.
// PARAMETERS
//  NUM_PE   4    number of PEs; must equal 2**LOG2_PE
//  LOG2_PE  2    log2(NUM_PE); the average is a right shift by LOG2_PE
//  TIMEOUT  255  max cycles spent in a WAIT state before ERR; 8-bit counter
// PORTS
//  Clk              in   1         clock, rising edge
//  Reset_n          in   1         asynchronous, active-low reset
//  Go               in   1         job request; sampled only in IDLE, DONE, ERR
//  threshold_in     in   8         threshold for this job; latched on accepted Go
//  bg_r_in/g/b      in   8 each    replacement background RGB; latched on accepted Go
//  pe_red_sum       in   8*NUM_PE  per-PE red sum, PE k at [8k+7:8k]; green/blue buses identical
//  pe_green_sum     in   8*NUM_PE
//  pe_blue_sum      in   8*NUM_PE
//  pe_sum_done      in   NUM_PE    per-PE Qsd
//  pe_bg_done       in   NUM_PE    per-PE Qbgd
//  Start_Sum        out  1         1-cycle pulse, all PEs
//  Start_BgRemoval  out  1         1-cycle pulse, all PEs
//  Ack              out  1         level acknowledge to all PEs
//  red_exp/green_exp/blue_exp  out  8 each  expected background colour
//  threshold        out  8         latched threshold
//  desired_bg_r/g/b out  8 each    latched replacement colour
//  Busy             out  1         1 in every state except IDLE, DONE, ERR
//  Done             out  1         1 while in DONE
//  Error            out  1         1 while in ERR
//  state_o          out  4         state encoding, debug
// BEHAVIOUR
//  Reset (async, Reset_n=0): state IDLE; every output 0; accumulators and counters 0.
//   Reset mid-job abandons the job; PEs see Start_*=0, Ack=0 immediately.
//  States: IDLE, S_START, S_WAIT, S_ACK, AVG, B_START, B_WAIT, B_ACK, DONE, ERR.
//  IDLE/DONE/ERR + Go=1 -> S_START; config latched, Done/Error cleared that edge. Go ignored elsewhere.
//  S_START: Start_Sum=1 for exactly this cycle -> S_WAIT; timeout counter cleared.
//  S_WAIT: pe_sum_done all ones (AND reduction) -> S_ACK; else count++; count==TIMEOUT -> ERR.
//  S_ACK: Ack=1; values on pe_*_sum captured into a holding register on entry edge;
//   stay until pe_sum_done all zero, then Ack=0 and -> AVG. Timeout also applies here.
//  AVG: sequential, one PE per cycle, index 0..NUM_PE-1; acc width 8+LOG2_PE, cleared on entry;
//   after NUM_PE cycles exp = acc >> LOG2_PE (truncate), registered onto *_exp -> B_START.
//   AVG latency exactly NUM_PE cycles; no overflow possible at this width.
//  B_START: Start_BgRemoval=1 one cycle; *_exp, threshold, desired_bg_* stable from this cycle to job end.
//  B_WAIT/B_ACK: same rules as S_WAIT/S_ACK on pe_bg_done; B_ACK exits -> DONE.
//  DONE: Done=1, Busy=0, outputs hold. ERR: Error=1, Ack=1 held (drives stuck PEs home), Busy=0.
//  Start_Sum and Start_BgRemoval are never high together; neither is high while Ack=1.
//  Done flags arriving early (before wait state) are only acted on in WAIT; partial sets never advance.
//  Min job latency with zero-delay PEs: 1+1+1+NUM_PE+1+1+1 cycles Go-edge to Done.
// TESTING
//  NUM_PE=4, all sums 61/133/198, PEs done 3 cycles after start -> exp 61/133/198; Done=1; one pulse per Start.
//  Red sums 10,20,30,41 -> red_exp=25 (101>>2 truncated); sums 255 x4 -> exp 255, no wrap.
//  pe_sum_done stuck at 4'b0111 -> Error=1 exactly TIMEOUT+1 cycles after S_WAIT entry, Ack=1, Busy=0.
//  Go pulsed during B_WAIT -> ignored, config unchanged; Go in DONE with threshold_in=40 -> new job, threshold=40.
//  Reset_n low during S_ACK -> same cycle Ack=0, all outputs 0, state_o=IDLE; next Go runs cleanly.
//  PE holds Qsd 5 cycles after Ack -> stays S_ACK, Ack high 5 cycles, then AVG; no second Start_Sum.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// Initiator side of the PE start/done/Ack handshake for one background-removal job:
// sum phase, sequential averaging of per-PE sums into the expected colour, then bg-removal phase.
module pe_array_ctrl #(
    parameter int NUM_PE  = 4,
    parameter int LOG2_PE = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                Go,
    input  logic [7:0]          threshold_in,
    input  logic [7:0]          bg_r_in,
    input  logic [7:0]          bg_g_in,
    input  logic [7:0]          bg_b_in,
    input  logic [8*NUM_PE-1:0] pe_red_sum,
    input  logic [8*NUM_PE-1:0] pe_green_sum,
    input  logic [8*NUM_PE-1:0] pe_blue_sum,
    input  logic [NUM_PE-1:0]   pe_sum_done,
    input  logic [NUM_PE-1:0]   pe_bg_done,
    output logic                Start_Sum,
    output logic                Start_BgRemoval,
    output logic                Ack,
    output logic [7:0]          red_exp,
    output logic [7:0]          green_exp,
    output logic [7:0]          blue_exp,
    output logic [7:0]          threshold,
    output logic [7:0]          desired_bg_r,
    output logic [7:0]          desired_bg_g,
    output logic [7:0]          desired_bg_b,
    output logic                Busy,
    output logic                Done,
    output logic                Error,
    output logic [3:0]          state_o
);

    localparam int AW = 8 + LOG2_PE;
    localparam int IW = (LOG2_PE > 0) ? LOG2_PE : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        S_START = 4'd1,
        S_WAIT  = 4'd2,
        S_ACK   = 4'd3,
        AVG     = 4'd4,
        B_START = 4'd5,
        B_WAIT  = 4'd6,
        B_ACK   = 4'd7,
        DONE    = 4'd8,
        ERR     = 4'd9
    } state_t;

    state_t              state, state_nx;
    logic [7:0]          tcnt;
    logic [8*NUM_PE-1:0] hold_r, hold_g, hold_b;
    logic [AW-1:0]       acc_r, acc_g, acc_b;
    logic [AW-1:0]       sum_r, sum_g, sum_b;
    logic [IW-1:0]       idx;
    logic [7:0]          sel_r, sel_g, sel_b;

    logic idle_like, go_ok, timed_out, in_wait, avg_last;
    logic sum_all, sum_none, bg_all, bg_none;

    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
    assign go_ok     = Go && idle_like;
    assign timed_out = (tcnt == 8'(TIMEOUT));
    assign in_wait   = (state == S_WAIT) || (state == S_ACK) || (state == B_WAIT) || (state == B_ACK);
    assign avg_last  = (idx == IW'(NUM_PE - 1));
    assign sum_all   = &pe_sum_done;
    assign sum_none  = ~|pe_sum_done;
    assign bg_all    = &pe_bg_done;
    assign bg_none   = ~|pe_bg_done;

    // One PE's captured sums per AVG cycle, selected by the running index.
    assign sel_r = hold_r[{idx, 3'b000} +: 8];
    assign sel_g = hold_g[{idx, 3'b000} +: 8];
    assign sel_b = hold_b[{idx, 3'b000} +: 8];
    assign sum_r = acc_r + AW'(sel_r);
    assign sum_g = acc_g + AW'(sel_g);
    assign sum_b = acc_b + AW'(sel_b);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: if (Go) state_nx = S_START;
            S_START:         state_nx = S_WAIT;
            S_WAIT: begin
                if (sum_all)        state_nx = S_ACK;
                else if (timed_out) state_nx = ERR;
            end
            S_ACK: begin
                if (sum_none)       state_nx = AVG;
                else if (timed_out) state_nx = ERR;
            end
            AVG:             if (avg_last) state_nx = B_START;
            B_START:         state_nx = B_WAIT;
            B_WAIT: begin
                if (bg_all)         state_nx = B_ACK;
                else if (timed_out) state_nx = ERR;
            end
            B_ACK: begin
                if (bg_none)        state_nx = DONE;
                else if (timed_out) state_nx = ERR;
            end
            default:         state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tcnt         <= '0;
            hold_r       <= '0;
            hold_g       <= '0;
            hold_b       <= '0;
            acc_r        <= '0;
            acc_g        <= '0;
            acc_b        <= '0;
            idx          <= '0;
            red_exp      <= '0;
            green_exp    <= '0;
            blue_exp     <= '0;
            threshold    <= '0;
            desired_bg_r <= '0;
            desired_bg_g <= '0;
            desired_bg_b <= '0;
        end else begin
            if (state_nx != state) tcnt <= '0;
            else if (in_wait)      tcnt <= tcnt + 8'd1;

            if (go_ok) begin
                threshold    <= threshold_in;
                desired_bg_r <= bg_r_in;
                desired_bg_g <= bg_g_in;
                desired_bg_b <= bg_b_in;
            end

            if (state == S_WAIT && sum_all) begin
                hold_r <= pe_red_sum;
                hold_g <= pe_green_sum;
                hold_b <= pe_blue_sum;
            end

            if (state == S_ACK && state_nx == AVG) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
                idx   <= '0;
            end else if (state == AVG) begin
                acc_r <= sum_r;
                acc_g <= sum_g;
                acc_b <= sum_b;
                idx   <= idx + IW'(1);
                // Last PE: the shift drops the fraction, giving a truncated mean.
                if (avg_last) begin
                    red_exp   <= 8'(sum_r >> LOG2_PE);
                    green_exp <= 8'(sum_g >> LOG2_PE);
                    blue_exp  <= 8'(sum_b >> LOG2_PE);
                end
            end
        end
    end

    // ERR keeps Ack high so PEs stuck with a done flag can return home.
    assign Start_Sum       = (state == S_START);
    assign Start_BgRemoval = (state == B_START);
    assign Ack             = (state == S_ACK) || (state == B_ACK) || (state == ERR);
    assign Busy            = !idle_like;
    assign Done            = (state == DONE);
    assign Error           = (state == ERR);
    assign state_o         = state;

endmodule
